ascon_state_readout: RTL and testbench

Serializes Ascon state words out of the core for the host, the read-direction counterpart of the serial state-write path (`state_shift_en/sel/lsb`). On a start request it snapshots one 64-bit state word or one 128-bit word pair (ciphertext block or tag) from `S_0_reg`..`S_4_reg` into a shift register. It then presents the snapshot MSB-first, one bit per host-side shift tick. It sits between the Ascon core outputs and the SPI MISO logic.

---
 rtl/ascon_pkg.sv | 49 ++++
 rtl/ascon_piso128.sv | 35 +++
 rtl/ascon_state_readout.sv | 126 ++++++++++++
 tb/tb_ascon_state_readout.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg
// Shared definitions for the Ascon core slice: readout select codes,
// readout FSM state encodings, operation-mode codes and Ascon core
// sequencing codes, plus a small helper for the readout width.
package ascon_pkg;

  localparam int STATE_W = 64;
  localparam int SHREG_W = 128;

  // Readout selections; codes 0..4 pick a single state word.
  typedef enum logic [2:0] {
    RD_SEL_S0      = 3'd0,
    RD_SEL_S1      = 3'd1,
    RD_SEL_S2      = 3'd2,
    RD_SEL_S3      = 3'd3,
    RD_SEL_S4      = 3'd4,
    RD_SEL_RATE    = 3'd5,
    RD_SEL_TAG     = 3'd6,
    RD_SEL_INVALID = 3'd7
  } rd_sel_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_SHIFT = 2'd1,
    RD_DONE  = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_HASH = 2'd2,
    MODE_XOF  = 2'd3
  } op_mode_t;

  typedef enum logic [2:0] {
    ASCON_IDLE  = 3'd0,
    ASCON_INIT  = 3'd1,
    ASCON_AD    = 3'd2,
    ASCON_PT    = 3'd3,
    ASCON_FINAL = 3'd4,
    ASCON_TAG   = 3'd5
  } ascon_state_t;

  // Word pairs (rate and tag) stream 128 bits, single words 64.
  function automatic logic rd_sel_is_wide(input logic [2:0] sel);
    return (sel == RD_SEL_RATE) || (sel == RD_SEL_TAG);
  endfunction

endpackage

// File: rtl/ascon_piso128.sv
// ascon_piso128
// 128-bit parallel-load, MSB-first shift register. Load has priority
// over shift; shifting fills zeros from the bottom.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture din this cycle
//   shift        shift left by one (zero fill)
//   din[127:0]   parallel load data
//   dout_bit     current MSB
module ascon_piso128
  import ascon_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [SHREG_W-1:0]   din,
  output logic                 dout_bit
);

  logic [SHREG_W-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[SHREG_W-2:0], 1'b0};
    end
  end

  assign dout_bit = shreg[SHREG_W-1];

endmodule

// File: rtl/ascon_state_readout.sv
// ascon_state_readout
// Snapshots one Ascon state word (64 bits) or a word pair (128 bits) into
// a shift register on request and presents it MSB-first, one bit per
// host shift tick, toward the SPI MISO logic.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   S_0_reg..S_4_reg    state words from the core
//   rd_start, rd_sel    readout request and selection (7 = invalid)
//   shift_tick          consume the current bit
//   rd_abort            cancel an in-progress readout
//   dout_bit            current serial bit
//   busy, done, rd_err  status: in progress, end pulse, bad-select pulse
//   bits_left           remaining bits including the current one
module ascon_state_readout
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] S_0_reg,
  input  logic [63:0] S_1_reg,
  input  logic [63:0] S_2_reg,
  input  logic [63:0] S_3_reg,
  input  logic [63:0] S_4_reg,
  input  logic        rd_start,
  input  logic [2:0]  rd_sel,
  input  logic        shift_tick,
  input  logic        rd_abort,
  output logic        dout_bit,
  output logic        busy,
  output logic        done,
  output logic        rd_err,
  output logic [7:0]  bits_left
);

  rd_state_t            state_q, state_d;
  logic [7:0]           bits_left_q, bits_left_d;
  logic [SHREG_W-1:0]   load_word;
  logic                 load_en, shift_en;
  logic                 start_ok, start_bad;
  logic                 rd_err_q;

  // Single words land in the upper half so the MSB always leads.
  always_comb begin
    load_word = '0;
    case (rd_sel)
      RD_SEL_S0:   load_word = {S_0_reg, 64'h0};
      RD_SEL_S1:   load_word = {S_1_reg, 64'h0};
      RD_SEL_S2:   load_word = {S_2_reg, 64'h0};
      RD_SEL_S3:   load_word = {S_3_reg, 64'h0};
      RD_SEL_S4:   load_word = {S_4_reg, 64'h0};
      RD_SEL_RATE: load_word = {S_0_reg, S_1_reg};
      RD_SEL_TAG:  load_word = {S_3_reg, S_4_reg};
      default:     load_word = '0;
    endcase
  end

  assign start_ok  = (state_q == RD_IDLE) && rd_start && (rd_sel != RD_SEL_INVALID);
  assign start_bad = (state_q == RD_IDLE) && rd_start && (rd_sel == RD_SEL_INVALID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      bits_left_q <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      rd_err_q    <= start_bad;
    end
  end

  // Abort takes priority over a same-cycle tick, so the tick is dropped
  // and the shift register keeps its current contents.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start_ok) begin
          load_en     = 1'b1;
          bits_left_d = rd_sel_is_wide(rd_sel) ? 8'd128 : 8'd64;
          state_d     = RD_SHIFT;
        end
      end
      RD_SHIFT: begin
        if (rd_abort) begin
          state_d     = RD_IDLE;
          bits_left_d = '0;
        end else if (shift_tick && (bits_left_q != 8'd0)) begin
          shift_en    = 1'b1;
          bits_left_d = bits_left_q - 8'd1;
          if (bits_left_q == 8'd1) begin
            state_d = RD_DONE;
          end
        end
      end
      RD_DONE: begin
        state_d = RD_IDLE;
        if (rd_abort) begin
          bits_left_d = '0;
        end
      end
      default: begin
        state_d     = RD_IDLE;
        bits_left_d = '0;
      end
    endcase
  end

  ascon_piso128 u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_en),
    .shift    (shift_en),
    .din      (load_word),
    .dout_bit (dout_bit)
  );

  assign busy      = (state_q != RD_IDLE);
  assign done      = (state_q == RD_DONE);
  assign rd_err    = rd_err_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_ascon_state_readout.sv
// tb_ascon_state_readout
// Scoreboard bench: each accepted start pushes the expected bit stream,
// each consumed bit is popped and compared against dout_bit.
module tb_ascon_state_readout;

  logic        clk;
  logic        rst_n;
  logic [63:0] S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg;
  logic        rd_start;
  logic [2:0]  rd_sel;
  logic        shift_tick;
  logic        rd_abort;
  logic        dout_bit;
  logic        busy;
  logic        done;
  logic        rd_err;
  logic [7:0]  bits_left;

  int          checks;
  int          errors;
  bit          exp_q[$];
  logic [127:0] captured;

  ascon_state_readout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .S_0_reg    (S_0_reg),
    .S_1_reg    (S_1_reg),
    .S_2_reg    (S_2_reg),
    .S_3_reg    (S_3_reg),
    .S_4_reg    (S_4_reg),
    .rd_start   (rd_start),
    .rd_sel     (rd_sel),
    .shift_tick (shift_tick),
    .rd_abort   (rd_abort),
    .dout_bit   (dout_bit),
    .busy       (busy),
    .done       (done),
    .rd_err     (rd_err),
    .bits_left  (bits_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs from a falling edge and returns at the next
  // falling edge, with outputs settled for sampling.
  task automatic applyStimulus(input logic start, input logic [2:0] sel,
                               input logic tick, input logic abort);
    rd_start   = start;
    rd_sel     = sel;
    shift_tick = tick;
    rd_abort   = abort;
    @(posedge clk);
    #1;
    rd_start   = 1'b0;
    rd_sel     = 3'd0;
    shift_tick = 1'b0;
    rd_abort   = 1'b0;
    @(negedge clk);
  endtask

  task automatic loadExpected(input logic [127:0] word, input int nbits);
    exp_q.delete();
    captured = '0;
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(word[127-i]);
    end
  endtask

  task automatic startReadout(input logic [2:0] sel, input logic [127:0] word,
                              input int nbits, input logic abort_too);
    loadExpected(word, nbits);
    applyStimulus(1'b1, sel, 1'b0, abort_too);
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_bits_left", bits_left, nbits);
  endtask

  task automatic tickAndCheck(input logic start_too);
    if (exp_q.size() == 0) begin
      checkOutput("sb_underflow", 1'b0, 1'b1);
    end else begin
      checkOutput("dout_bit", dout_bit, exp_q[0]);
      checkOutput("bits_left", bits_left, exp_q.size());
      checkOutput("busy_mid", busy, 1'b1);
      checkOutput("done_early", done, 1'b0);
      captured = {captured[126:0], dout_bit};
      void'(exp_q.pop_front());
    end
    applyStimulus(start_too, 3'd3, 1'b1, 1'b0);
  endtask

  task automatic finishReadout();
    checkOutput("sb_empty", exp_q.size(), 0);
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_busy", busy, 1'b1);
    checkOutput("done_bits_left", bits_left, 8'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("done_clear", done, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    captured   = '0;
    rst_n      = 1'b0;
    rd_start   = 1'b0;
    rd_sel     = 3'd0;
    shift_tick = 1'b0;
    rd_abort   = 1'b0;
    S_0_reg    = '0;
    S_1_reg    = '0;
    S_2_reg    = 64'h8000_0000_0000_0001;
    S_3_reg    = 64'h0123_4567_89AB_CDEF;
    S_4_reg    = 64'hFEDC_BA98_7654_3210;

    #3;
    checkOutput("rst_dout", dout_bit, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", rd_err, 1'b0);
    checkOutput("rst_bits_left", bits_left, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single word sel=2, back-to-back ticks");
    startReadout(3'd2, {64'h8000_0000_0000_0001, 64'h0}, 64, 1'b0);
    for (int i = 0; i < 64; i++) tickAndCheck(1'b0);
    checkOutput("s2_stream", captured[63:0], 64'h8000_0000_0000_0001);
    finishReadout();

    $display("[TB] tag sel=6, random gaps");
    startReadout(3'd6, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, 128, 1'b0);
    for (int i = 0; i < 128; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      tickAndCheck(1'b0);
    end
    checkOutput("tag_stream", captured, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
    finishReadout();

    $display("[TB] snapshot sel=0");
    S_0_reg = 64'hAAAA_AAAA_AAAA_AAAA;
    startReadout(3'd0, {64'hAAAA_AAAA_AAAA_AAAA, 64'h0}, 64, 1'b0);
    for (int i = 0; i < 5; i++) tickAndCheck(1'b0);
    S_0_reg = '0;
    for (int i = 5; i < 64; i++) tickAndCheck(1'b0);
    checkOutput("snap_stream", captured[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
    finishReadout();

    $display("[TB] abort during sel=5");
    S_0_reg = 64'hFFC0_0000_0000_0000;
    S_1_reg = 64'h1122_3344_5566_7788;
    startReadout(3'd5, {64'hFFC0_0000_0000_0000, 64'h1122_3344_5566_7788}, 128, 1'b0);
    for (int i = 0; i < 9; i++) tickAndCheck(1'b0);
    checkOutput("abort_pre_bits", bits_left, 8'd119);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_bits_left", bits_left, 8'd0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_held_bit", dout_bit, 1'b1);
    startReadout(3'd5, {64'hFFC0_0000_0000_0000, 64'h1122_3344_5566_7788}, 128, 1'b1);
    for (int i = 0; i < 128; i++) tickAndCheck(1'b0);
    checkOutput("restart_stream", captured, {64'hFFC0_0000_0000_0000, 64'h1122_3344_5566_7788});
    finishReadout();

    $display("[TB] invalid select and start while busy");
    applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
    checkOutput("err_pulse", rd_err, 1'b1);
    checkOutput("err_busy", busy, 1'b0);
    checkOutput("err_dout", dout_bit, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("err_clear", rd_err, 1'b0);
    S_1_reg = 64'h5555_5555_0F0F_3C3C;
    startReadout(3'd1, {64'h5555_5555_0F0F_3C3C, 64'h0}, 64, 1'b0);
    for (int i = 0; i < 20; i++) tickAndCheck(1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    checkOutput("busy_start_bits", bits_left, 8'd44);
    for (int i = 20; i < 64; i++) tickAndCheck(i == 30);
    checkOutput("busy_start_stream", captured[63:0], 64'h5555_5555_0F0F_3C3C);
    finishReadout();

    $display("[TB] asynchronous reset mid-stream");
    S_0_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    startReadout(3'd0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 64, 1'b0);
    for (int i = 0; i < 30; i++) tickAndCheck(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_dout", dout_bit, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_done", done, 1'b0);
    checkOutput("arst_err", rd_err, 1'b0);
    checkOutput("arst_bits_left", bits_left, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    S_4_reg = 64'hDEAD_BEEF_CAFE_F00D;
    startReadout(3'd4, {64'hDEAD_BEEF_CAFE_F00D, 64'h0}, 64, 1'b0);
    for (int i = 0; i < 64; i++) tickAndCheck(1'b0);
    checkOutput("post_rst_stream", captured[63:0], 64'hDEAD_BEEF_CAFE_F00D);
    finishReadout();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
